// File: rtl/burst_fill_engine.sv
// Rectangle fill engine: turns one corner-pair command into burst-aligned masked row writes.
// Optional FILL_CLIP_EN clamps oversize rectangles to the frame instead of rejecting them.
module burst_fill_engine #(
  parameter int FB_WIDTH     = 640,
  parameter int FB_HEIGHT    = 480,
  parameter int PIXEL_BITS   = 24,
  parameter int BURST_PIXELS = 64,
  parameter int LAYERS       = 2,
  parameter int COORD_BITS   = 16,
  parameter int ADDR_BITS    = 24,
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               fill_mode,
  input  logic [COORD_BITS-1:0]              x0,
  input  logic [COORD_BITS-1:0]              y0,
  input  logic [COORD_BITS-1:0]              x1,
  input  logic [COORD_BITS-1:0]              y1,
  input  logic [PIXEL_BITS-1:0]              color,
  input  logic [LW-1:0]                      layer,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output logic [ADDR_BITS-1:0]               wr_addr,
  output logic [BURST_PIXELS*PIXEL_BITS-1:0] wr_data,
  output logic [BURST_PIXELS-1:0]            wr_mask
);
  localparam int BPL = $clog2(BURST_PIXELS);
  localparam int BPR = FB_WIDTH / BURST_PIXELS;
  localparam logic [COORD_BITS-1:0] XLIM = COORD_BITS'(FB_WIDTH);
  localparam logic [COORD_BITS-1:0] YLIM = COORD_BITS'(FB_HEIGHT);
  localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(BPR);
  localparam logic [ADDR_BITS-1:0] LAYER_STRIDE = ADDR_BITS'(BPR * FB_HEIGHT);
  localparam logic [LW:0] LAYER_LIM = (LW+1)'(LAYERS);

  typedef enum logic [1:0] {IDLE, SETUP, ROW, DONE} state_t;
  state_t state;

  logic [COORD_BITS-1:0] cx0, cy0, cx1, cy1;
  logic                  cmode;
  logic [LW-1:0]         clayer;
  logic [PIXEL_BITS-1:0] ccolor;
  logic [COORD_BITS-1:0] xmin, xmax, ymin, ymax, y, bx;

  logic [COORD_BITS-1:0] s_xmin, s_xmax, s_ymin, s_ymax, s_bx0;
  logic                  s_rej, layer_bad;
  logic [COORD_BITS-1:0] bx_first, bx_last, nxt_y, nxt_bx;
  logic                  full_row, row_end, last_burst;

  function automatic logic [BURST_PIXELS-1:0] row_mask(
    input logic [COORD_BITS-1:0] xl, xh, yl, yh, yy, bb,
    input logic md
  );
    logic [COORD_BITS-1:0] px;
    logic full;
    row_mask = '0;
    full = !md || (yy == yl) || (yy == yh);
    for (int i = 0; i < BURST_PIXELS; i++) begin
      px = (bb << BPL) + COORD_BITS'(i);
      row_mask[i] = full ? (px >= xl && px <= xh) : (px == xl || px == xh);
    end
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_of(
    input logic [LW-1:0] lay,
    input logic [COORD_BITS-1:0] yy, bb
  );
    addr_of = ADDR_BITS'(lay) * LAYER_STRIDE + ADDR_BITS'(yy) * ROW_STRIDE + ADDR_BITS'(bb);
  endfunction

  assign layer_bad = {1'b0, clayer} >= LAYER_LIM;

  // Normalise corners; the reject decision uses the pre-clamp values.
  always_comb begin
    s_xmin = (cx0 < cx1) ? cx0 : cx1;
    s_xmax = (cx0 < cx1) ? cx1 : cx0;
    s_ymin = (cy0 < cy1) ? cy0 : cy1;
    s_ymax = (cy0 < cy1) ? cy1 : cy0;
`ifdef FILL_CLIP_EN
    s_rej = (s_xmin >= XLIM) || (s_ymin >= YLIM) || layer_bad;
    if (s_xmax >= XLIM) s_xmax = XLIM - 1'b1;
    if (s_ymax >= YLIM) s_ymax = YLIM - 1'b1;
`else
    s_rej = (s_xmax >= XLIM) || (s_ymax >= YLIM) || layer_bad;
`endif
    s_bx0 = s_xmin >> BPL;
  end

  // Outline middle rows jump straight from the xmin burst to the xmax burst.
  always_comb begin
    bx_first   = xmin >> BPL;
    bx_last    = xmax >> BPL;
    full_row   = !cmode || (y == ymin) || (y == ymax);
    row_end    = (bx == bx_last);
    last_burst = row_end && (y == ymax);
    nxt_y      = row_end ? y + 1'b1 : y;
    nxt_bx     = row_end ? bx_first : (full_row ? bx + 1'b1 : bx_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_mask  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cx0    <= x0;
            cy0    <= y0;
            cx1    <= x1;
            cy1    <= y1;
            cmode  <= fill_mode;
            clayer <= layer;
            ccolor <= color;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          xmin <= s_xmin;
          xmax <= s_xmax;
          ymin <= s_ymin;
          ymax <= s_ymax;
          if (s_rej) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            y        <= s_ymin;
            bx       <= s_bx0;
            wr_valid <= 1'b1;
            wr_addr  <= addr_of(clayer, s_ymin, s_bx0);
            wr_mask  <= row_mask(s_xmin, s_xmax, s_ymin, s_ymax, s_ymin, s_bx0, cmode);
            wr_data  <= {BURST_PIXELS{ccolor}};
            state    <= ROW;
          end
        end
        ROW: begin
          if (wr_ready) begin
            if (last_burst) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              y       <= nxt_y;
              bx      <= nxt_bx;
              wr_addr <= addr_of(clayer, nxt_y, nxt_bx);
              wr_mask <= row_mask(xmin, xmax, ymin, ymax, nxt_y, nxt_bx, cmode);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_fill_engine.sv
// Scoreboard bench for burst_fill_engine: a reference pixel-set model queues expected bursts.
module tb_burst_fill_engine;
  localparam int W = 640, H = 480, PB = 24, BP = 64, L = 2, CW = 16, AW = 24;
  localparam int BPR = W / BP;
  localparam int LIMIT = 2000;

  logic clk, rst, start, fill_mode;
  logic [CW-1:0] x0, y0, x1, y1;
  logic [PB-1:0] color;
  logic [0:0] layer;
  logic busy, done, err, wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [BP*PB-1:0] wr_data;
  logic [BP-1:0] wr_mask;

  burst_fill_engine #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB), .BURST_PIXELS(BP),
    .LAYERS(L), .COORD_BITS(CW), .ADDR_BITS(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fill_mode(fill_mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .layer(layer),
    .busy(busy), .done(done), .err(err), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BP-1:0] mask;
    logic [PB-1:0] color;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int hs_in_cmd = 0;
  int stall_left = 0;
  bit ready_rand = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bad_lanes(input logic [BP*PB-1:0] d, input logic [PB-1:0] c);
    int b = 0;
    for (int i = 0; i < BP; i++) if (d[i*PB +: PB] !== c) b++;
    return b;
  endfunction

  // Enumerates every burst of every row and keeps those touching the pixel set.
  task automatic build_expected(input int ax0, ay0, ax1, ay1, input bit md, input int lay,
                                input logic [PB-1:0] col, output bit rej, output int n);
    int xl, xh, yl, yh;
    logic [BP-1:0] m;
    exp_t e;
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
`ifdef FILL_CLIP_EN
    rej = (xl >= W) || (yl >= H) || (lay >= L);
    if (xh >= W) xh = W - 1;
    if (yh >= H) yh = H - 1;
`else
    rej = (xh >= W) || (yh >= H) || (lay >= L);
`endif
    n = 0;
    if (!rej) begin
      for (int yy = yl; yy <= yh; yy++) begin
        for (int b = 0; b < BPR; b++) begin
          m = '0;
          for (int i = 0; i < BP; i++) begin
            int px;
            px = b * BP + i;
            if (md && yy != yl && yy != yh) m[i] = (px == xl) || (px == xh);
            else m[i] = (px >= xl) && (px <= xh);
          end
          if (m != '0) begin
            e.addr = AW'(lay * BPR * H + yy * BPR + b);
            e.mask = m;
            e.color = col;
            exp_q.push_back(e);
            n++;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      check("write_expected", (exp_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
      if (exp_q.size() != 0) begin
        check("wr_addr", wr_addr, exp_q[0].addr);
        check("wr_mask", wr_mask, exp_q[0].mask);
        check("wr_data_bad_lanes", bad_lanes(wr_data, exp_q[0].color), 0);
        if (wr_ready) begin
          void'(exp_q.pop_front());
          hs_in_cmd++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_rand) wr_ready = ($urandom_range(0, 3) != 0);
    else if (wr_valid && hs_in_cmd == 1 && stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else wr_ready = 1'b1;
  end

  task automatic run_cmd(input int ax0, ay0, ax1, ay1, input bit md, input int lay,
                         input logic [PB-1:0] col, input int stall, input bit chk_lat,
                         input bit poke_busy, input bit poke_done);
    bit rej, seen;
    int n, k;
    build_expected(ax0, ay0, ax1, ay1, md, lay, col, rej, n);
    hs_in_cmd = 0;
    stall_left = stall;
    @(negedge clk);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    fill_mode = md; layer = 1'(lay); color = col; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x0 = 16'd5; y0 = 16'd5; x1 = 16'd9; y1 = 16'd9; color = 24'h0000AA;
    seen = 0;
    for (k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_setup", busy, 1);
        check("valid_setup", wr_valid, 0);
      end
      if (k == 2 && !rej) check("valid_first", wr_valid, 1);
      start = poke_busy && (k == 3);
      if (done) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (seen) begin
      check("err", err, rej);
      check("busy_at_done", busy, 0);
      if (chk_lat) check("done_latency", k, rej ? 2 : n + 2 + stall);
      check("write_count", hs_in_cmd, n);
      check("writes_left", exp_q.size(), 0);
      if (poke_done) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_start_ignored", busy, 0);
        check("done_single_pulse", done, 0);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rej;
    int n, k;
    rst = 1'b1; start = 1'b0; fill_mode = 1'b0; wr_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0; layer = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_mask", wr_mask, 0);
    check("rst_data_bad_lanes", bad_lanes(wr_data, '0), 0);
    rst = 1'b0;

    run_cmd(0, 0, 63, 0, 0, 0, 24'hFF0000, 0, 1, 0, 0);
    run_cmd(70, 1, 130, 2, 0, 0, 24'h00FF00, 0, 1, 1, 0);
    run_cmd(130, 2, 70, 1, 0, 0, 24'h00FF00, 5, 1, 0, 0);
    run_cmd(0, 0, 639, 2, 1, 1, 24'h123456, 0, 1, 0, 1);
    run_cmd(600, 0, 700, 0, 0, 0, 24'hABCDEF, 0, 1, 0, 0);
    run_cmd(10, 5, 20, 8, 1, 1, 24'h0F0F0F, 0, 1, 0, 0);
    run_cmd(100, 4, 100, 0, 1, 0, 24'h777777, 0, 1, 0, 0);
    ready_rand = 1;
    run_cmd(200, 9, 5, 3, 1, 0, 24'h55AA55, 0, 0, 0, 0);
    ready_rand = 0;

    build_expected(0, 0, 639, 479, 0, 0, 24'hC0FFEE, rej, n);
    hs_in_cmd = 0;
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 16'd639; y1 = 16'd479; fill_mode = 0; layer = 0;
    color = 24'hC0FFEE; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      if (hs_in_cmd >= 3) break;
    end
    check("hs_before_rst", hs_in_cmd, 3);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", wr_valid, 0);
    check("midrst_addr", wr_addr, 0);
    check("midrst_mask", wr_mask, 0);
    check("midrst_done", done, 0);
    check("midrst_data_bad_lanes", bad_lanes(wr_data, '0), 0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_no_write", wr_valid, 0);
    end
    run_cmd(0, 0, 0, 0, 0, 0, 24'h010203, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
